// File: rtl/ucie_sb_tx_serializer_if.sv
// Upstream packet handshake bundle for the sideband transmit serializer.
// Latency: none (wires only).
// Backpressure: tx_ready low holds the producer; tx_data must stay stable while stalled.
interface ucie_sb_tx_serializer_if #(
   parameter int PKT_BITS = 64
);
   logic                tx_valid;
   logic                tx_ready;
   logic [PKT_BITS-1:0] tx_data;

   // Packet producer side
   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   // Serializer side
   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );
endinterface

// File: rtl/ucie_sb_tx_serializer.sv
// UCIe sideband TX: buffers 64-bit packets and shifts them LSB-first with a forwarded clock and idle gap.
// Latency: push at edge N into an empty idle block -> pop at N+1 -> bit 0 on SBTX_DATA at N+2.
// Backpressure: tx_ready (registered) is low while the FIFO is full; no bypass on a same-cycle pop.
module ucie_sb_tx_serializer #(
   parameter int PKT_BITS   = 64,
   parameter int GAP_UI     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   ucie_sb_tx_serializer_if.slave  tx,
   output logic                    SBTX_CLK,
   output logic                    SBTX_DATA,
   output logic                    busy,
   output logic                    pkt_sent
);

   localparam int BCW = (PKT_BITS > 1) ? $clog2(PKT_BITS) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = PW + 1;
   localparam int GCW = 9;

   localparam logic [BCW-1:0] LAST_BIT = BCW'(PKT_BITS - 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(2 * GAP_UI - 1);
   localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Packet FIFO
   // ---------------------------------------------------------------
   logic [PKT_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                tx_ready_q;
   logic                empty;
   logic                push;
   logic                pop;
   logic [PKT_BITS-1:0] head_dat;

   assign empty       = (count_q == '0);
   assign push        = tx.tx_valid && tx_ready_q;
   assign head_dat    = mem_q[rd_ptr_q];
   assign tx.tx_ready = tx_ready_q;

   // FIFO pointer/occupancy next-state; pointers wrap naturally at a power-of-2 depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO control registers; ready is registered from the next occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_ready_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_ready_q <= (count_d != DEPTH_C);
      end
   end

   // FIFO storage; a push presented alongside reset is dropped
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= tx.tx_data;
      end
   end

   // ---------------------------------------------------------------
   // Serializer FSM
   // ---------------------------------------------------------------
   state_t              state_q, state_d;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                ph_q, ph_d;
   logic [GCW-1:0]      gap_cnt_q, gap_cnt_d;
   logic [PKT_BITS-1:0] shift_q, shift_d;

   // State and datapath register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         ph_q      <= 1'b0;
         gap_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         ph_q      <= ph_d;
         gap_cnt_q <= gap_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // Next-state: pop on entry to SHIFT, two clk phases per UI, exact gap then reload or idle
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      ph_d      = ph_q;
      gap_cnt_d = gap_cnt_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = head_dat;
               bit_cnt_d = '0;
               ph_d      = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d = 1'b0;
               if (bit_cnt_q == LAST_BIT) begin
                  gap_cnt_d = '0;
                  state_d   = ST_GAP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               if (!empty) begin
                  // Reload straight into SHIFT so the gap is not stretched by an IDLE cycle
                  pop       = 1'b1;
                  shift_d   = head_dat;
                  bit_cnt_d = '0;
                  ph_d      = 1'b0;
                  state_d   = ST_SHIFT;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GCW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   logic sbtx_clk_q,  sbtx_clk_d;
   logic sbtx_data_q, sbtx_data_d;
   logic pkt_sent_q,  pkt_sent_d;
   logic busy_q,      busy_d;

   // Output decode: clock high on phase 1, data held across both phases of a UI
   always_comb begin
      sbtx_clk_d  = 1'b0;
      sbtx_data_d = 1'b0;
      pkt_sent_d  = 1'b0;
      busy_d      = (state_q != ST_IDLE) || !empty;
      if (state_q == ST_SHIFT) begin
         sbtx_clk_d  = ph_q;
         sbtx_data_d = shift_q[bit_cnt_q];
         pkt_sent_d  = ph_q && (bit_cnt_q == LAST_BIT);
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sbtx_clk_q  <= 1'b0;
         sbtx_data_q <= 1'b0;
         pkt_sent_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sbtx_clk_q  <= sbtx_clk_d;
         sbtx_data_q <= sbtx_data_d;
         pkt_sent_q  <= pkt_sent_d;
         busy_q      <= busy_d;
      end
   end

   assign SBTX_CLK  = sbtx_clk_q;
   assign SBTX_DATA = sbtx_data_q;
   assign pkt_sent  = pkt_sent_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ucie_sb_tx_serializer.sv
// Directed bench for the sideband TX serializer (default gap and a GAP_UI=40 instance).
// Latency: n/a.
// Backpressure: driver holds each packet until it sees tx_ready before the sampling edge.
module tb_ucie_sb_tx_serializer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   int n_checks = 0;
   int n_fail   = 0;

   logic sbclk0, sbdat0, sent0, busy0;
   logic sbclk1, sbdat1, sent1, busy1;

   ucie_sb_tx_serializer_if #(.PKT_BITS(64)) if0 ();
   ucie_sb_tx_serializer_if #(.PKT_BITS(64)) if1 ();

   ucie_sb_tx_serializer #(.PKT_BITS(64), .GAP_UI(32), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .reset(reset), .tx(if0),
      .SBTX_CLK(sbclk0), .SBTX_DATA(sbdat0), .busy(busy0), .pkt_sent(sent0)
   );

   ucie_sb_tx_serializer #(.PKT_BITS(64), .GAP_UI(40), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .reset(reset), .tx(if1),
      .SBTX_CLK(sbclk1), .SBTX_DATA(sbdat1), .busy(busy1), .pkt_sent(sent1)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   logic [63:0] pk  [0:7];
   int          rel [0:7];
   int          push_edge [0:7];
   logic        rdy_log [0:1299];
   logic [63:0] rx0 [$];
   logic [63:0] rx1 [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected {SBTX_CLK, SBTX_DATA, pkt_sent, busy} in cycle k for n back-to-back packets
   // whose first push lands at edge 0; packet j bit 0 first appears at cycle 2 + j*period.
   function automatic logic [3:0] exp_out(input int k, input int n, input int gap);
      logic [3:0] r;
      int per, s, o, last;
      r   = 4'b0;
      per = 128 + 2 * gap;
      if (n > 0) begin
         last = 2 + (n - 1) * per + 127 + 2 * gap;
         r[0] = (k >= 1) && (k <= last);
         for (int j = 0; j < n; j++) begin
            s = 2 + j * per;
            o = k - s;
            if (o >= 0 && o < 128) begin
               r[3] = o[0];
               r[2] = pk[j][o / 2];
               r[1] = (o == 127);
            end
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] dut_out(input int sel);
      return (sel != 0) ? {sbclk1, sbdat1, sent1, busy1} : {sbclk0, sbdat0, sent0, busy0};
   endfunction

   function automatic logic get_rdy(input int sel);
      return (sel != 0) ? if1.tx_ready : if0.tx_ready;
   endfunction

   task automatic set_in(input int sel, input logic vld, input logic [63:0] dat);
      if (sel != 0) begin
         if1.tx_valid = vld;
         if1.tx_data  = dat;
      end else begin
         if0.tx_valid = vld;
         if0.tx_data  = dat;
      end
   endtask

   // Called right after the negedge of cycle -1; pushes pk[i] no earlier than edge rel[i].
   task automatic run_seq(input int tn, input int sel, input int n, input int gap,
                          input int len, input int chk_rdy);
      int   idx;
      logic vld, accept;
      idx = 0;
      vld = (rel[0] <= 0);
      set_in(sel, vld, pk[0]);
      accept = vld && get_rdy(sel);
      for (int k = 0; k <= len; k++) begin
         @(negedge clk);
         if (accept) begin
            push_edge[idx] = k;
            idx++;
         end
         check($sformatf("t%0d_out_k%0d", tn, k), 64'(dut_out(sel)), 64'(exp_out(k, n, gap)));
         rdy_log[k] = get_rdy(sel);
         if (chk_rdy != 0)
            check($sformatf("t%0d_rdy_k%0d", tn, k), 64'(get_rdy(sel)), 64'd1);
         vld = (idx < n) && (k + 1 >= rel[idx]);
         set_in(sel, vld, pk[idx]);
         accept = vld && get_rdy(sel);
      end
      set_in(sel, 1'b0, 64'd0);
   endtask

   task automatic sb_check(input int tn, input int sel, input int n);
      int sz;
      sz = (sel != 0) ? rx1.size() : rx0.size();
      check($sformatf("t%0d_rx_count", tn), 64'(sz), 64'(n));
      for (int i = 0; i < n && i < sz; i++)
         check($sformatf("t%0d_rx%0d", tn, i), (sel != 0) ? rx1[i] : rx0[i], pk[i]);
   endtask

   // Receiver model for each instance: sample data on every SBTX_CLK rising edge,
   // reassemble LSB-first, and check rise-to-rise spacing across a packet boundary.
   int          nb0 = 0, last_end0 = -1;
   logic        prev0 = 1'b0;
   logic [63:0] acc0 = '0;
   initial forever begin
      @(negedge clk);
      if (!busy0) begin
         nb0       = 0;
         last_end0 = -1;
      end
      if (sbclk0 && !prev0) begin
         if (nb0 == 0 && last_end0 >= 0)
            check("gap0_rise_to_rise", 64'(cyc - last_end0), 64'(2 * 32 + 2));
         acc0 = {sbdat0, acc0[63:1]};
         nb0++;
         if (nb0 == 64) begin
            rx0.push_back(acc0);
            nb0       = 0;
            last_end0 = cyc;
         end
      end
      prev0 = sbclk0;
   end

   int          nb1 = 0, last_end1 = -1;
   logic        prev1 = 1'b0;
   logic [63:0] acc1 = '0;
   initial forever begin
      @(negedge clk);
      if (!busy1) begin
         nb1       = 0;
         last_end1 = -1;
      end
      if (sbclk1 && !prev1) begin
         if (nb1 == 0 && last_end1 >= 0)
            check("gap1_rise_to_rise", 64'(cyc - last_end1), 64'(2 * 40 + 2));
         acc1 = {sbdat1, acc1[63:1]};
         nb1++;
         if (nb1 == 64) begin
            rx1.push_back(acc1);
            nb1       = 0;
            last_end1 = cyc;
         end
      end
      prev1 = sbclk1;
   end

   initial begin
      set_in(0, 1'b0, 64'd0);
      set_in(1, 1'b0, 64'd0);

      // Reset state
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_out0", 64'(dut_out(0)), 64'd0);
         check("rst_out1", 64'(dut_out(1)), 64'd0);
         check("rst_rdy0", 64'(get_rdy(0)), 64'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_rdy0", 64'(get_rdy(0)), 64'd1);
      check("post_rst_rdy1", 64'(get_rdy(1)), 64'd1);
      check("post_rst_busy0", 64'(busy0), 64'd0);

      // Test 1: single packet, only bit 0 set
      rx0.delete();
      pk[0] = 64'h0000_0000_0000_0001; rel[0] = 0;
      run_seq(1, 0, 1, 32, 197, 1);
      sb_check(1, 0, 1);

      // Test 2: back-to-back all-ones then A5 pattern
      rx0.delete();
      pk[0] = 64'hFFFF_FFFF_FFFF_FFFF; rel[0] = 0;
      pk[1] = 64'hA5A5_A5A5_A5A5_A5A5; rel[1] = 1;
      run_seq(2, 0, 2, 32, 390, 1);
      sb_check(2, 0, 2);

      // Test 3: backpressure with six packets and valid held high
      rx0.delete();
      pk[0] = 64'h0123_4567_89AB_CDEF; pk[1] = 64'hFEDC_BA98_7654_3210;
      pk[2] = 64'hDEAD_BEEF_0000_FFFF; pk[3] = 64'h8000_0000_0000_0003;
      pk[4] = 64'h5555_AAAA_3333_CCCC; pk[5] = 64'h0F0F_F0F0_1234_8765;
      for (int i = 0; i < 6; i++) rel[i] = 0;
      run_seq(3, 0, 6, 32, 1158, 0);
      check("t3_rdy_k3",   64'(rdy_log[3]),   64'd1);
      check("t3_rdy_k4",   64'(rdy_log[4]),   64'd0);
      check("t3_rdy_k192", 64'(rdy_log[192]), 64'd0);
      check("t3_rdy_k193", 64'(rdy_log[193]), 64'd1);
      check("t3_rdy_k194", 64'(rdy_log[194]), 64'd0);
      check("t3_rdy_k385", 64'(rdy_log[385]), 64'd1);
      check("t3_push4_edge", 64'(push_edge[4]), 64'd4);
      check("t3_push5_edge", 64'(push_edge[5]), 64'd194);
      sb_check(3, 0, 6);

      // Test 4: reset at cycle 50 with a push presented alongside it
      rx0.delete();
      pk[0] = 64'h1111_2222_3333_4444; rel[0] = 0;
      pk[1] = 64'h9999_8888_7777_6666; rel[1] = 1;
      run_seq(4, 0, 2, 32, 49, 1);
      @(negedge clk);
      check("t4_out_k50", 64'(dut_out(0)), 64'(exp_out(50, 2, 32)));
      reset = 1'b1;
      set_in(0, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
      @(negedge clk);
      check("t4_out_k51", 64'(dut_out(0)), 64'd0);
      check("t4_rdy_k51", 64'(get_rdy(0)), 64'd0);
      reset = 1'b0;
      set_in(0, 1'b0, 64'd0);
      pk[0] = 64'hC3C3_0000_FFFF_0001; rel[0] = 0;
      for (int k = 52; k <= 59; k++) begin
         @(negedge clk);
         check($sformatf("t4_out_k%0d", k), 64'(dut_out(0)), 64'(exp_out(k - 60, 1, 32)));
         check($sformatf("t4_rdy_k%0d", k), 64'(get_rdy(0)), 64'd1);
      end
      run_seq(4, 0, 1, 32, 197, 1);
      sb_check(4, 0, 1);

      // Test 5: push lands on the gap-end pop edge
      rx0.delete();
      pk[0] = 64'hAAAA_0000_5555_0001; rel[0] = 0;
      pk[1] = 64'h0000_0000_FFFF_FFFF; rel[1] = 2;
      pk[2] = 64'h8421_8421_8421_8421; rel[2] = 193;
      run_seq(5, 0, 3, 32, 582, 1);
      check("t5_push2_edge", 64'(push_edge[2]), 64'd193);
      sb_check(5, 0, 3);

      // Test 6: GAP_UI=40 instance, two back-to-back packets
      rx1.delete();
      pk[0] = 64'h7E57_0001_CAFE_F00D; rel[0] = 0;
      pk[1] = 64'h0000_FFFF_0000_FFFF; rel[1] = 1;
      run_seq(6, 1, 2, 40, 422, 1);
      sb_check(6, 1, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
